// File: rtl/dtg_pkg.sv
// dtg_pkg: XGA 1024x768@70 timing defaults and frame-size helpers shared by dtg, scaler and colorizer
package dtg_pkg;
  localparam int XGA_H_ACTIVE = 1024;
  localparam int XGA_H_FP = 24;
  localparam int XGA_H_SYNC = 136;
  localparam int XGA_H_BP = 144;
  localparam int XGA_V_ACTIVE = 768;
  localparam int XGA_V_FP = 3;
  localparam int XGA_V_SYNC = 6;
  localparam int XGA_V_BP = 29;
  localparam int CNT_W = 12;
  function automatic int h_total(int active, int fp, int sync, int bp);
    return active + fp + sync + bp;
  endfunction
  function automatic int v_total(int active, int fp, int sync, int bp);
    return active + fp + sync + bp;
  endfunction
endpackage

// File: rtl/dtg_wrap_counter.sv
// dtg_wrap_counter: 12-bit modulo-N counter with enable; resets to N-1 and exposes its next value
module dtg_wrap_counter import dtg_pkg::*; #(
  parameter int N = 1328
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_next,
  output logic             wrap
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);
  always_comb begin
    wrap = en && (count == LAST);
    count_next = wrap ? '0 : en ? count + 1'b1 : count;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) count <= LAST;
    else count <= count_next;
endmodule

// File: rtl/dtg.sv
// dtg: display timing generator, free-running col/row counters with registered sync and video_on
// Optional frame_tick port with DTG_FRAME_TICK_EN.
module dtg import dtg_pkg::*; #(
  parameter int H_ACTIVE = XGA_H_ACTIVE,
  parameter int H_FP = XGA_H_FP,
  parameter int H_SYNC = XGA_H_SYNC,
  parameter int H_BP = XGA_H_BP,
  parameter int V_ACTIVE = XGA_V_ACTIVE,
  parameter int V_FP = XGA_V_FP,
  parameter int V_SYNC = XGA_V_SYNC,
  parameter int V_BP = XGA_V_BP,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  output logic             horiz_sync,
  output logic             vert_sync,
  output logic             video_on,
  output logic [CNT_W-1:0] pixel_col,
`ifdef DTG_FRAME_TICK_EN
  output logic [CNT_W-1:0] pixel_row,
  output logic             frame_tick
`else
  output logic [CNT_W-1:0] pixel_row
`endif
);
  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam logic [CNT_W-1:0] HA = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] HS0 = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS1 = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VA = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] VS0 = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS1 = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_too_big
    $error("dtg: H_TOTAL/V_TOTAL exceed 12-bit counters");
  end
  logic [CNT_W-1:0] col_next, row_next;
  logic col_wrap, row_wrap;
  dtg_wrap_counter #(.N(H_TOTAL)) u_col (
    .clock(clock), .reset(reset), .en(1'b1),
    .count(pixel_col), .count_next(col_next), .wrap(col_wrap)
  );
  dtg_wrap_counter #(.N(V_TOTAL)) u_row (
    .clock(clock), .reset(reset), .en(col_wrap),
    .count(pixel_row), .count_next(row_next), .wrap(row_wrap)
  );
  // Flags decode the counters' next values so they line up with pixel_col/pixel_row.
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      video_on <= 1'b0;
      horiz_sync <= ~SYNC_POL;
      vert_sync <= ~SYNC_POL;
    end else begin
      video_on <= (col_next < HA) && (row_next < VA);
      horiz_sync <= (col_next >= HS0 && col_next < HS1) ? SYNC_POL : ~SYNC_POL;
      vert_sync <= (row_next >= VS0 && row_next < VS1) ? SYNC_POL : ~SYNC_POL;
    end
`ifdef DTG_FRAME_TICK_EN
  always_ff @(posedge clock or negedge reset)
    if (!reset) frame_tick <= 1'b0;
    else frame_tick <= (col_next == '0) && (row_next == VA);
`endif
endmodule

// File: doc/dtg.md
# dtg

Display timing generator for the 1024x768 video path. Free-running horizontal/vertical counters on the 75 MHz pixel clock produce VESA 1024x768@70 Hz sync, the active-video flag, and the `pixel_row`/`pixel_col` coordinates. These coordinates feed the downstream scaler, which maps them to the 128x128 map address, and the colorizer.

## Interface
- `H_ACTIVE`, 1024, visible columns
- `H_FP`, 24, horizontal front porch (clocks)
- `H_SYNC`, 136, horizontal sync width (clocks)
- `H_BP`, 144, horizontal back porch (clocks)
- `V_ACTIVE`, 768, visible rows
- `V_FP`, 3, vertical front porch (lines)
- `V_SYNC`, 6, vertical sync width (lines)
- `V_BP`, 29, vertical back porch (lines)
- `SYNC_POL`, 0, active level of both sync outputs (0 = active-low)
- `clock`  in  1  75 MHz pixel clock; one clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `horiz_sync`  out  1  horizontal sync, polarity per `SYNC_POL`
- `vert_sync`  out  1  vertical sync, polarity per `SYNC_POL`
- `video_on`  out  1  high when the current pixel is inside the visible area
- `pixel_col`  out  12  current column, 0..H_TOTAL-1
- `pixel_row`  out  12  current row, 0..V_TOTAL-1
- `frame_tick`  out  1  one-cycle start-of-vblank pulse (only with `DTG_FRAME_TICK_EN`)

## Operation
- Derived values: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 1328); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 806).
- Column counter increments every clock and wraps from H_TOTAL-1 to 0.
- Row counter increments only on a column wrap and wraps from V_TOTAL-1 to 0; row and column wrap on the same edge at end of frame.
- Counters are 12 bits; a parameter set with H_TOTAL or V_TOTAL > 4096 is illegal and fails elaboration.
- All outputs are registers and are mutually consistent in every cycle. For outputs (c, r):
  - `video_on` = (c < H_ACTIVE) && (r < V_ACTIVE)
  - `horiz_sync` is active iff H_ACTIVE+H_FP <= c < H_ACTIVE+H_FP+H_SYNC, so default columns 1048..1183
  - `vert_sync` is active iff V_ACTIVE+V_FP <= r < V_ACTIVE+V_FP+V_SYNC, so default rows 771..776
- `vert_sync` depends on row only: it changes when the column wraps to 0, not mid-line.
- Sync and `video_on` are decoded from next-state counter values, so they carry no lag relative to `pixel_col`/`pixel_row`.
- `pixel_col`/`pixel_row` report raw counts during blanking and are not clamped. Consumers gate on `video_on`.

## Timing
- Reset values (asserted asynchronously, immediately):
  - `pixel_col` = H_TOTAL-1 (1327), `pixel_row` = V_TOTAL-1 (805)
  - `video_on` = 0
  - `horiz_sync`/`vert_sync` inactive (1 for `SYNC_POL`=0)
  - `frame_tick` = 0
- The reset state is the last back-porch pixel of the frame. The first rising edge after reset release presents (0,0) with `video_on`=1, so no frame is truncated or duplicated.
- Reset asserted mid-frame returns all outputs to the reset values asynchronously. Release is synchronised by the top-level reset synchroniser, not inside this block.
- Line period: H_TOTAL clocks. Frame period: H_TOTAL*V_TOTAL = 1,070,368 clocks, about 70.07 Hz at 75 MHz.
- The downstream scaler adds its own register stages. Pipeline alignment of sync against pixel data is handled at the top level, not here.

## Configuration
- `DTG_FRAME_TICK_EN` defined:
  - `frame_tick` port exists.
  - It is high for exactly one clock, in the cycle where `pixel_col`=0 and `pixel_row`=V_ACTIVE (768), i.e. the first blanking line.
  - Intended as the once-per-frame update strobe for bot/icon logic.
- Macro undefined: port and logic are absent. All other behaviour is identical.

## Structure
- `dtg_pkg`: XGA default timing constants and derived H_TOTAL/V_TOTAL helper functions. These are shared with the scaler and colorizer.
- Sub-module `dtg_wrap_counter`: a parameterised 12-bit modulo-N counter with enable and wrap output. It is instantiated twice: column with enable tied high, row enabled by the column wrap.

## Test plan
- Reset held, then released → (1327,805), `video_on`=0, syncs high during reset; first edge after release gives (0,0), `video_on`=1.
- Line sweep → `video_on` falls at col 1024; `horiz_sync` low for cols 1048..1183 (136 clocks); col wraps 1327→0 with row incrementing.
- Frame sweep → `vert_sync` low for rows 771..776 (6 lines of 1328 clocks each); row wraps 805→0 at col wrap; frame length 1,070,368 clocks.
- Reset asserted at (500,300) → outputs return to reset values within the same cycle without waiting for a clock; restart begins again at (0,0).
- `DTG_FRAME_TICK_EN` defined, 3 frames run → exactly 3 single-cycle `frame_tick` pulses, each at (0,768), spaced 1,070,368 clocks apart.
- `SYNC_POL`=1 → sync waveforms inverted with identical positions; `video_on` and counters unchanged.
